// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer: fetch, decode, exec, mem, write-back, sticky halt
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [31:0] imm,
  input  logic        alu_cond,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic [1:0]  r_err;
  logic [7:0]  r_wait;
  logic        r_retire;

  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic        w_wait_hit;
  logic        w_legal;
  // Write-back is implied by the instruction class; rd=x0 is filtered by the register file.
  logic        w_unused_reg_write;

  assign w_unused_reg_write = reg_write;
  assign w_pc4      = r_pc + 32'd4;
  assign w_target   = r_pc + (alu_cond ? imm : 32'd4);
  assign w_wait_hit = (r_wait == WAIT_LIMIT);

  always_comb begin
    case (r_instr[6:0])
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH: w_legal = 1'b1;
      default:                                            w_legal = 1'b0;
    endcase
  end

  // r_run holds off the first fetch until one edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_run     <= 1'b0;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0000_0013;
      r_instret <= 32'd0;
      r_err     <= 2'd0;
      r_wait    <= 8'd0;
      r_retire  <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_retire <= 1'b0;
      if (r_run) begin
        case (r_state)
          S_FETCH: begin
            if (imem_ready) begin
              r_instr <= imem_rdata;
              r_state <= S_DECODE;
            end else if (w_wait_hit) begin
              r_state <= S_HALT;
              r_err   <= 2'd2;
            end else begin
              r_wait <= r_wait + 8'd1;
            end
          end
          S_DECODE: begin
            if (w_legal) begin
              r_state <= S_EXEC;
            end else begin
              r_state <= S_HALT;
              r_err   <= 2'd1;
            end
          end
          S_EXEC: begin
            if (branch) begin
              if (w_target[1:0] != 2'b00) begin
                r_state <= S_HALT;
                r_err   <= 2'd3;
              end else begin
                r_pc      <= w_target;
                r_instret <= r_instret + 32'd1;
                r_retire  <= 1'b1;
                r_wait    <= 8'd0;
                r_state   <= S_FETCH;
              end
            end else if (mem_read || mem_write) begin
              r_wait  <= 8'd0;
              r_state <= S_MEM;
            end else begin
              r_state <= S_WB;
            end
          end
          S_MEM: begin
            if (dmem_ready) begin
              if (mem_read) begin
                r_state <= S_WB;
              end else begin
                r_pc      <= w_pc4;
                r_instret <= r_instret + 32'd1;
                r_retire  <= 1'b1;
                r_wait    <= 8'd0;
                r_state   <= S_FETCH;
              end
            end else if (w_wait_hit) begin
              r_state <= S_HALT;
              r_err   <= 2'd2;
            end else begin
              r_wait <= r_wait + 8'd1;
            end
          end
          S_WB: begin
            r_pc      <= w_pc4;
            r_instret <= r_instret + 32'd1;
            r_retire  <= 1'b1;
            r_wait    <= 8'd0;
            r_state   <= S_FETCH;
          end
          S_HALT: r_state <= S_HALT;
          default: begin
            r_state <= S_HALT;
            r_err   <= 2'd1;
          end
        endcase
      end
    end
  end

  assign imem_req  = r_run && (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign dmem_req  = (r_state == S_MEM);
  assign dmem_we   = dmem_req && mem_write;
  assign rf_we     = (r_state == S_WB);
  assign rf_wsel   = rf_we && mem_read;
  assign pc        = r_pc;
  assign retire    = r_retire;
  assign instret   = r_instret;
  assign halted    = (r_state == S_HALT);
  assign err_code  = r_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl: vector table, corner sequences, random vs model
module tb_multicycle_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TO  = 4;

  localparam logic [31:0] W_ADDI = 32'h0050_0093;
  localparam logic [31:0] W_BEQ  = 32'h0000_0063;
  localparam logic [31:0] W_LW   = 32'h0000_a103;
  localparam logic [31:0] W_SW   = 32'h0020_a023;
  localparam logic [31:0] W_ADD  = 32'h0020_81b3;
  localparam logic [31:0] W_LUI  = 32'h1234_50b7;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0] imem_addr, imem_rdata, instr, imm, pc, instret;
  logic        branch, mem_read, mem_write, reg_write, alu_cond;
  logic        rf_we, rf_wsel, retire, halted;
  logic [1:0]  err_code;

  multicycle_ctrl #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .imm(imm), .alu_cond(alu_cond), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .pc(pc), .retire(retire), .instret(instret),
    .halted(halted), .err_code(err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    logic        br, mr, mw, rw;
    logic [31:0] imm;
    logic        cond;
    int          fdly, mdly;
    int          e_cyc;
    logic [31:0] e_pc;
    logic [1:0]  e_err;
    int          e_rfwe;
    logic        e_wsel;
    int          e_dmem;
    logic        e_we;
    logic [31:0] e_instret;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  vec_t        tbl[10];
  vec_t        rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63};
  endfunction

  function automatic vec_t mk(input logic [31:0] word, input logic [31:0] im, input logic cond,
                              input int fdly, input int mdly, input int e_cyc, input logic [31:0] e_pc,
                              input logic [1:0] e_err, input int e_rfwe, input logic e_wsel,
                              input int e_dmem, input logic e_we, input logic [31:0] e_instret);
    vec_t v;
    logic [6:0] o;
    o = word[6:0];
    v.word = word; v.imm = im; v.cond = cond; v.fdly = fdly; v.mdly = mdly;
    v.br = (o == 7'h63); v.mr = (o == 7'h03); v.mw = (o == 7'h23);
    v.rw = (o == 7'h03) || (o == 7'h13) || (o == 7'h33);
    v.e_cyc = e_cyc; v.e_pc = e_pc; v.e_err = e_err; v.e_rfwe = e_rfwe; v.e_wsel = e_wsel;
    v.e_dmem = e_dmem; v.e_we = e_we; v.e_instret = e_instret;
    return v;
  endfunction

  // Reference: latency is the sum of per-phase costs; halts leave pc and instret untouched.
  function automatic void model(inout vec_t v, input logic [31:0] cur_pc, input logic [31:0] cur_ir);
    int cyc;
    logic [31:0] tgt;
    v.e_err = 0; v.e_rfwe = 0; v.e_wsel = 0; v.e_dmem = 0; v.e_we = 0;
    v.e_pc = cur_pc; v.e_instret = cur_ir;
    if (v.fdly >= TO) begin v.e_cyc = TO; v.e_err = 2; return; end
    cyc = v.fdly + 1;
    if (!is_legal(v.word[6:0])) begin v.e_cyc = cyc + 1; v.e_err = 1; return; end
    cyc += 2;
    if (v.br) begin
      tgt = cur_pc + (v.cond ? v.imm : 32'd4);
      v.e_cyc = cyc;
      if (tgt % 4 != 0) begin v.e_err = 3; return; end
      v.e_pc = tgt; v.e_instret = cur_ir + 1;
      return;
    end
    if (v.mr || v.mw) begin
      v.e_we = v.mw;
      if (v.mdly >= TO) begin v.e_dmem = TO; v.e_cyc = cyc + TO; v.e_err = 2; return; end
      v.e_dmem = v.mdly + 1;
      cyc += v.mdly + 1;
    end
    if (!v.mw) begin v.e_rfwe = 1; v.e_wsel = v.mr; cyc += 1; end
    v.e_pc = cur_pc + 4; v.e_instret = cur_ir + 1; v.e_cyc = cyc;
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = 32'd0;
    branch = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; imm = 32'd0; alu_cond = 1'b0;
    step();
    check({tag, "/rst_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "/rst_dmem_req"}, 32'(dmem_req), 32'd0);
    check({tag, "/rst_rf_we"},    32'(rf_we),    32'd0);
    check({tag, "/rst_retire"},   32'(retire),   32'd0);
    check({tag, "/rst_halted"},   32'(halted),   32'd0);
    check({tag, "/rst_pc"},       pc,            RPC);
    check({tag, "/rst_instr"},    instr,         32'h0000_0013);
    check({tag, "/rst_instret"},  instret,       32'd0);
    check({tag, "/rst_err"},      32'(err_code), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check({tag, "/rel_imem_req"},  32'(imem_req), 32'd1);
    check({tag, "/rel_imem_addr"}, imem_addr,     RPC);
    exp_pc = RPC;
    exp_instret = 32'd0;
  endtask

  task automatic exec_one(input string tag, input vec_t v, input bit abort_in_mem);
    int   fcnt = 0, dcnt = 0, rfwe_cnt = 0, dmem_cnt = 0, cyc = 0;
    logic wsel_seen = 1'b0, we_seen = 1'b0, fetched = 1'b0, done = 1'b0;
    check({tag, "/imem_addr"}, imem_addr, exp_pc);
    check({tag, "/imem_req"},  32'(imem_req), 32'd1);
    while (!done && cyc < 60) begin
      if (fetched) begin
        branch = v.br; mem_read = v.mr; mem_write = v.mw; reg_write = v.rw; imm = v.imm; alu_cond = v.cond;
      end else begin
        branch = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
        reg_write = 1'($urandom); imm = $urandom; alu_cond = 1'($urandom);
      end
      imem_ready = imem_req && (fcnt == v.fdly);
      imem_rdata = imem_ready ? v.word : $urandom;
      dmem_ready = dmem_req && (dcnt == v.mdly);
      if (imem_req) fcnt++;
      if (dmem_req) begin dcnt++; dmem_cnt++; we_seen = dmem_we; end
      if (rf_we) begin rfwe_cnt++; wsel_seen = rf_wsel; end
      if (abort_in_mem && dmem_req) begin
        #2 reset = 1'b0;
        #1;
        check({tag, "/abort_dmem_req"}, 32'(dmem_req), 32'd0);
        check({tag, "/abort_pc"},       pc,            RPC);
        return;
      end
      if (imem_req && imem_ready) fetched = 1'b1;
      step();
      cyc++;
      if (cyc == 1 && v.e_cyc > 1) check({tag, "/retire_pulse"}, 32'(retire), 32'd0);
      if (retire || halted) done = 1'b1;
    end
    check({tag, "/finished"}, 32'(done),     32'd1);
    check({tag, "/cycles"},   cyc,           v.e_cyc);
    check({tag, "/pc"},       pc,            v.e_pc);
    check({tag, "/instret"},  instret,       v.e_instret);
    check({tag, "/err"},      32'(err_code), 32'(v.e_err));
    check({tag, "/halted"},   32'(halted),   32'(v.e_err != 2'd0));
    check({tag, "/rf_we"},    rfwe_cnt,      v.e_rfwe);
    check({tag, "/dmem_cyc"}, dmem_cnt,      v.e_dmem);
    if (v.e_rfwe > 0) check({tag, "/rf_wsel"}, 32'(wsel_seen), 32'(v.e_wsel));
    if (v.e_dmem > 0) check({tag, "/dmem_we"}, 32'(we_seen),   32'(v.e_we));
    if (v.fdly < TO)  check({tag, "/instr"},   instr,          v.word);
    if (v.e_err != 2'd0) begin
      for (int k = 0; k < 3; k++) begin
        imem_ready = 1'b1; dmem_ready = 1'b1;
        step();
        check({tag, "/hold_halted"},   32'(halted),   32'd1);
        check({tag, "/hold_imem_req"}, 32'(imem_req | dmem_req | rf_we | retire), 32'd0);
        check({tag, "/hold_pc"},       pc,            v.e_pc);
        check({tag, "/hold_err"},      32'(err_code), 32'(v.e_err));
      end
      imem_ready = 1'b0; dmem_ready = 1'b0;
    end else begin
      exp_pc = v.e_pc;
      exp_instret = v.e_instret;
    end
  endtask

  initial begin
    tbl[0] = mk(W_ADDI, 32'd0,          1'b0, 0, 0, 4, 32'h04, 2'd0, 1, 1'b0, 0, 1'b0, 32'd1);
    tbl[1] = mk(W_BEQ,  32'd12,         1'b1, 0, 0, 3, 32'h10, 2'd0, 0, 1'b0, 0, 1'b0, 32'd2);
    tbl[2] = mk(W_BEQ,  32'hFFFF_FFF8,  1'b1, 0, 0, 3, 32'h08, 2'd0, 0, 1'b0, 0, 1'b0, 32'd3);
    tbl[3] = mk(W_BEQ,  32'd8,          1'b1, 0, 0, 3, 32'h10, 2'd0, 0, 1'b0, 0, 1'b0, 32'd4);
    tbl[4] = mk(W_BEQ,  32'hFFFF_FFF8,  1'b0, 0, 0, 3, 32'h14, 2'd0, 0, 1'b0, 0, 1'b0, 32'd5);
    tbl[5] = mk(W_LW,   32'd0,          1'b0, 0, 3, 8, 32'h18, 2'd0, 1, 1'b1, 4, 1'b0, 32'd6);
    tbl[6] = mk(W_SW,   32'd0,          1'b0, 0, 0, 4, 32'h1C, 2'd0, 0, 1'b0, 1, 1'b1, 32'd7);
    tbl[7] = mk(W_ADD,  32'd0,          1'b0, 3, 0, 7, 32'h20, 2'd0, 1, 1'b0, 0, 1'b0, 32'd8);
    tbl[8] = mk(W_SW,   32'd0,          1'b0, 0, 3, 7, 32'h24, 2'd0, 0, 1'b0, 4, 1'b1, 32'd9);
    tbl[9] = mk(W_BEQ,  32'd2,          1'b0, 0, 0, 3, 32'h28, 2'd0, 0, 1'b0, 0, 1'b0, 32'd10);

    do_reset("por");
    for (int i = 0; i < 10; i++) exec_one($sformatf("tbl%0d", i), tbl[i], 1'b0);

    // pc wraps through 0xFFFF_FFFC back to zero
    exec_one("wrap_br", mk(W_BEQ, 32'hFFFF_FFD4, 1'b1, 0, 0, 3, 32'hFFFF_FFFC, 2'd0, 0, 1'b0, 0, 1'b0, 32'd11), 1'b0);
    exec_one("wrap_op", mk(W_ADDI, 32'd0, 1'b0, 0, 0, 4, 32'h0, 2'd0, 1, 1'b0, 0, 1'b0, 32'd12), 1'b0);

    exec_one("abort", mk(W_LW, 32'd0, 1'b0, 0, 3, 0, 32'h0, 2'd0, 0, 1'b0, 0, 1'b0, 32'd0), 1'b1);
    do_reset("mid_mem");
    exec_one("resume", mk(W_ADDI, 32'd0, 1'b0, 0, 0, 4, 32'h04, 2'd0, 1, 1'b0, 0, 1'b0, 32'd1), 1'b0);

    exec_one("lui", mk(W_LUI, 32'd0, 1'b0, 0, 0, 2, 32'h04, 2'd1, 0, 1'b0, 0, 1'b0, 32'd1), 1'b0);
    do_reset("after_lui");
    exec_one("misalign", mk(W_BEQ, 32'd2, 1'b1, 0, 0, 3, 32'h0, 2'd3, 0, 1'b0, 0, 1'b0, 32'd0), 1'b0);
    do_reset("after_mis");
    exec_one("ftimeout", mk(W_ADDI, 32'd0, 1'b0, TO, 0, TO, 32'h0, 2'd2, 0, 1'b0, 0, 1'b0, 32'd0), 1'b0);
    do_reset("after_fto");
    exec_one("mtimeout", mk(W_LW, 32'd0, 1'b0, 0, TO, 3 + TO, 32'h0, 2'd2, 0, 1'b0, TO, 1'b0, 32'd0), 1'b0);
    do_reset("after_mto");

    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [31:0] w;
      logic [6:0]  o;
      r = $urandom_range(0, 99);
      w = $urandom;
      if (r < 4) begin
        o = 7'($urandom_range(0, 127));
        if (is_legal(o)) o = 7'h37;
      end else if (r < 30) o = 7'h63;
      else if (r < 50) o = 7'h03;
      else if (r < 65) o = 7'h23;
      else if (r < 82) o = 7'h33;
      else o = 7'h13;
      w[6:0] = o;
      rv = mk(w, 32'd0, 1'($urandom), 0, 0, 0, 32'd0, 2'd0, 0, 1'b0, 0, 1'b0, 32'd0);
      if ($urandom_range(0, 15) == 0) rv.imm = 32'($urandom_range(0, 31)) - 32'd16;
      else rv.imm = 32'($urandom_range(0, 32)) * 32'd4 - 32'd64;
      rv.fdly = ($urandom_range(0, 99) < 3) ? TO : int'($urandom_range(0, 3));
      rv.mdly = ($urandom_range(0, 99) < 3) ? TO : int'($urandom_range(0, 3));
      model(rv, exp_pc, exp_instret);
      exec_one($sformatf("rnd%0d", n), rv, 1'b0);
      if (rv.e_err != 2'd0) do_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
